// File: rtl/crc_seq_pkg.sv
// Shared types and constants for the CRC engine sequencer.
package crc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        LAT,
        READ,
        HOLD
    } crc_seq_state_t;

    localparam int          CRC_WIDTH = 16;
    localparam logic [15:0] CRC_POLY  = 16'h1021;

    // Counter width for a down-counter spanning 0..value-1 (never less than 1 bit).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/crc_seq_shifter.sv
// WIDTH-bit shift/assemble register: parallel load, MSB-first shift-out,
// and indexed single-bit capture used to rebuild the CRC read back from the engine.
module crc_seq_shifter
    import crc_seq_pkg::*;
#(
    parameter int WIDTH = CRC_WIDTH,
    parameter int CW    = clog2(WIDTH)
) (
    input  logic             clk_sys_i,
    input  logic             rst_b_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic             sample_i,
    input  logic [CW-1:0]    sample_idx_i,
    input  logic             sample_bit_i,
    output logic             msb_o,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_sys_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= load_data_i;
        end else if (shift_i) begin
            data_q <= {data_q[WIDTH-2:0], 1'b0};
        end else if (sample_i) begin
            data_q[sample_idx_i] <= sample_bit_i;
        end
    end

    assign msb_o  = data_q[WIDTH-1];
    assign data_o = data_q;

endmodule

// File: rtl/crc_sequencer.sv
// Sequences the serial CRC engine for whole words: shift the word in, read the CRC back out.
// Build option CRC_SEQ_AUTORUN_EN: free-running mode that relaunches whenever IN_DATA changes.
//
// state | meaning
// IDLE  | ready for a word (IN_READY high)
// SHIFT | word bits go MSB-first to DATA_IN, one per clock
// LAT   | READ_MODE high, waiting READ_LAT cycles for the first CRC bit
// READ  | CRC_OUT sampled MSB-first into the assemble register
// HOLD  | RES_VALID high until the consumer takes the result
module crc_sequencer
    import crc_seq_pkg::*;
#(
    parameter int WIDTH    = CRC_WIDTH,
    parameter int READ_LAT = 1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] RES_DATA,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic             DATA_IN,
    output logic             READ_MODE,
    input  logic             CRC_OUT,
    output logic             BUSY
);

    localparam int            CW      = clog2(WIDTH);
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAT_TOP = CW'((READ_LAT > 0) ? (READ_LAT - 1) : 0);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    crc_seq_state_t   state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_ready_q;
    logic [WIDTH-1:0] res_data_q, res_data_d;

    logic             launch;
    logic             accept;
    logic             sh_load, sh_shift, sh_sample;
    logic             sh_msb;
    logic [WIDTH-1:0] sh_data;

    crc_seq_shifter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_shifter (
        .clk_sys_i    (CLK),
        .rst_b_i      (RESET_N),
        .load_i       (sh_load),
        .load_data_i  (IN_DATA),
        .shift_i      (sh_shift),
        .sample_i     (sh_sample),
        .sample_idx_i (cnt_q),
        .sample_bit_i (CRC_OUT),
        .msb_o        (sh_msb),
        .data_o       (sh_data)
    );

`ifdef CRC_SEQ_AUTORUN_EN
    logic [WIDTH-1:0] last_q;
    logic             armed_q;
    logic             unused_hs;

    assign unused_hs = IN_VALID ^ RES_READY;
    assign launch    = in_ready_q && (!armed_q || (IN_DATA != last_q));
    assign accept    = 1'b1;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            last_q  <= '0;
            armed_q <= 1'b0;
        end else if ((state_q == IDLE) && launch) begin
            last_q  <= IN_DATA;
            armed_q <= 1'b1;
        end
    end
`else
    assign launch = IN_VALID && in_ready_q;
    assign accept = RES_READY;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        sh_sample  = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    sh_load = 1'b1;
                    cnt_d   = CNT_TOP;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sh_shift = 1'b1;
                cnt_d    = cnt_q - CNT_ONE;
                if (cnt_q == '0) begin
                    if (READ_LAT == 0) begin
                        state_d = READ;
                        cnt_d   = CNT_TOP;
                    end else begin
                        state_d = LAT;
                        cnt_d   = LAT_TOP;
                    end
                end
            end
            LAT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == '0) begin
                    state_d = READ;
                    cnt_d   = CNT_TOP;
                end
            end
            READ: begin
                sh_sample = 1'b1;
                cnt_d     = cnt_q - CNT_ONE;
                if (cnt_q == '0) begin
                    // Last bit lands in bit 0 on this same edge, so merge it into the published copy.
                    state_d       = HOLD;
                    cnt_d         = '0;
                    res_data_d    = sh_data;
                    res_data_d[0] = CRC_OUT;
                end
            end
            HOLD: begin
                if (accept) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= (state_d == IDLE);
            res_data_q <= res_data_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign RES_DATA  = res_data_q;
    assign RES_VALID = (state_q == HOLD);
    assign DATA_IN   = (state_q == SHIFT) && sh_msb;
    assign READ_MODE = (state_q == LAT) || (state_q == READ);
    assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_crc_sequencer.sv
// Bench for crc_sequencer: behavioural serial CRC engine plus a polynomial-division reference.
module tb_crc_sequencer;
    import crc_seq_pkg::*;

    parameter int RL = 1;
    localparam int EXP_LAT = 2 * CRC_WIDTH + RL;

    logic        CLK      = 1'b0;
    logic        RESET_N  = 1'b0;
    logic [15:0] IN_DATA  = 16'h0000;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [15:0] RES_DATA;
    logic        RES_VALID;
    logic        RES_READY = 1'b0;
    logic        DATA_IN;
    logic        READ_MODE;
    logic        CRC_OUT;
    logic        BUSY;

    int errors = 0;
    int checks = 0;
    int rd_violations = 0;
    int runs = 0;
    logic busy_prev = 1'b0;

    logic [15:0] eng_q;
    int          eng_wait;

    always #5 CLK = ~CLK;

    crc_sequencer #(
        .WIDTH    (CRC_WIDTH),
        .READ_LAT (RL)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .RES_DATA  (RES_DATA),
        .RES_VALID (RES_VALID),
        .RES_READY (RES_READY),
        .DATA_IN   (DATA_IN),
        .READ_MODE (READ_MODE),
        .CRC_OUT   (CRC_OUT),
        .BUSY      (BUSY)
    );

    // Serial engine: absorbs DATA_IN while not reading; in read mode, after RL cycles, emits MSB-first and shifts zeros in.
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            eng_q    <= 16'h0000;
            eng_wait <= 0;
        end else if (!READ_MODE) begin
            eng_wait <= 0;
            eng_q    <= {eng_q[14:0], 1'b0} ^ (((eng_q[15] ^ DATA_IN) == 1'b1) ? CRC_POLY : 16'h0000);
        end else if (eng_wait < RL) begin
            eng_wait <= eng_wait + 1;
        end else begin
            eng_q <= {eng_q[14:0], 1'b0};
        end
    end

    assign CRC_OUT = READ_MODE && (eng_wait == RL) && eng_q[15];

    always @(negedge CLK) begin
        if (READ_MODE === 1'b1 && DATA_IN !== 1'b0) rd_violations <= rd_violations + 1;
        if (BUSY === 1'b1 && busy_prev === 1'b0) runs <= runs + 1;
        busy_prev <= BUSY;
    end

    // Reference: remainder of word * x^16 divided by x^16 + CRC_POLY.
    function automatic logic [15:0] crc_ref(input logic [15:0] w);
        logic [31:0] r;
        logic [31:0] p;
        r = {w, 16'h0000};
        p = {15'h0000, 1'b1, CRC_POLY};
        for (int i = 31; i >= 16; i--) begin
            if (r[i]) r = r ^ (p << (i - 16));
        end
        return r[15:0];
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [15:0] w, output bit ok);
        IN_DATA  = w;
        IN_VALID = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (IN_READY === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
        IN_VALID = 1'b0;
    endtask

    task automatic wait_result(input int start, output int lat);
        lat = start;
        while (RES_VALID !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        RESET_N   = 1'b0;
        IN_VALID  = 1'b0;
        RES_READY = 1'b0;
        repeat (3) step();
        checks++;
        if ({IN_READY, RES_VALID, DATA_IN, READ_MODE, BUSY} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b expected 00000", {IN_READY, RES_VALID, DATA_IN, READ_MODE, BUSY});
        end
        checks++;
        if (RES_DATA !== 16'h0000) begin
            errors++;
            $display("FAIL reset_res_data: got %h expected 0000", RES_DATA);
        end
        RESET_N = 1'b1;
        #1;
        checks++;
        if (IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 0", IN_READY);
        end
        step();
        checks++;
        if ({IN_READY, BUSY} !== 2'b10) begin
            errors++;
            $display("FAIL reset_first_cycle: got ready/busy %b expected 10", {IN_READY, BUSY});
        end
    endtask

`ifdef CRC_SEQ_AUTORUN_EN
    task automatic test_autorun();
        int k;
        int r0;
        RES_READY = 1'b0;
        IN_VALID  = 1'b0;
        step();
        k = 0;
        while (BUSY !== 1'b0 && k < 200) begin
            step();
            k++;
        end
        repeat (3) step();
        r0 = runs;
        for (int t = 0; t < 2; t++) begin
            IN_DATA = (t == 0) ? 16'h0001 : 16'h0003;
            k = 0;
            while (RES_VALID !== 1'b1 && k < 200) begin
                step();
                k++;
            end
            checks++;
            if (k != EXP_LAT + 1) begin
                errors++;
                $display("FAIL auto_latency: got %0d expected %0d", k, EXP_LAT + 1);
            end
            checks++;
            if (RES_DATA !== crc_ref(IN_DATA)) begin
                errors++;
                $display("FAIL auto_result: got %h expected %h", RES_DATA, crc_ref(IN_DATA));
            end
            step();
            checks++;
            if (RES_VALID !== 1'b0) begin
                errors++;
                $display("FAIL auto_hold_one_cycle: got %b expected 0", RES_VALID);
            end
            repeat (40) step();
            checks++;
            if (runs != r0 + t + 1 || BUSY !== 1'b0) begin
                errors++;
                $display("FAIL auto_run_count: got %0d busy %b expected %0d busy 0", runs - r0, BUSY, t + 1);
            end
        end
        checks++;
        if (RES_DATA !== 16'h3063) begin
            errors++;
            $display("FAIL auto_final: got %h expected 3063", RES_DATA);
        end
    endtask
`else
    task automatic test_single();
        bit ok;
        int lat;
        logic [15:0] shifted;
        bit bad;
        RES_READY = 1'b1;
        send(16'h0001, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_handshake: got no IN_READY expected handshake");
        end
        shifted = 16'h0000;
        bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            shifted = {shifted[14:0], DATA_IN};
            if (READ_MODE !== 1'b0 || BUSY !== 1'b1) bad = 1'b1;
            if (i < 15) step();
        end
        checks++;
        if (shifted !== 16'h0001 || bad) begin
            errors++;
            $display("FAIL single_data_in: got %h ctl_bad %0d expected 0001 ctl_bad 0", shifted, bad);
        end
        step();
        checks++;
        if ({READ_MODE, DATA_IN} !== 2'b10) begin
            errors++;
            $display("FAIL single_read_mode: got %b expected 10", {READ_MODE, DATA_IN});
        end
        wait_result(16, lat);
        checks++;
        if (lat != EXP_LAT) begin
            errors++;
            $display("FAIL single_latency: got %0d expected %0d", lat, EXP_LAT);
        end
        checks++;
        if (RES_DATA !== 16'h1021 || READ_MODE !== 1'b0) begin
            errors++;
            $display("FAIL single_result: got %h rm %b expected 1021 rm 0", RES_DATA, READ_MODE);
        end
        step();
        checks++;
        if ({RES_VALID, BUSY} !== 2'b00 || RES_DATA !== 16'h1021) begin
            errors++;
            $display("FAIL single_accept: got valid/busy %b data %h expected 00 data 1021", {RES_VALID, BUSY}, RES_DATA);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int low;
        int lat;
        int lat2;
        logic [15:0] got;
        bit bad;
        RES_READY = 1'b1;
        send(16'h0003, ok);
        IN_DATA  = 16'h0000;
        IN_VALID = 1'b1;
        low = 0;
        lat = -1;
        got = 16'hxxxx;
        bad = 1'b0;
        while (IN_READY !== 1'b1 && low < 200) begin
            if (BUSY !== 1'b1) bad = 1'b1;
            if (RES_VALID === 1'b1 && lat < 0) begin
                lat = low;
                got = RES_DATA;
            end
            low++;
            step();
        end
        checks++;
        if (!ok || lat != EXP_LAT || got !== 16'h3063) begin
            errors++;
            $display("FAIL b2b_first: got lat %0d data %h expected lat %0d data 3063", lat, got, EXP_LAT);
        end
        checks++;
        if (low != EXP_LAT + 1 || bad || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_span: got %0d busy_bad %0d expected %0d busy_bad 0", low, bad, EXP_LAT + 1);
        end
        step();
        IN_VALID = 1'b0;
        wait_result(0, lat2);
        checks++;
        if (lat2 != EXP_LAT || RES_DATA !== 16'h0000) begin
            errors++;
            $display("FAIL b2b_second: got lat %0d data %h expected lat %0d data 0000", lat2, RES_DATA, EXP_LAT);
        end
        step();
    endtask

    task automatic test_hold_stall();
        bit ok;
        int lat;
        bit bad;
        logic [15:0] exp;
        exp = crc_ref(16'h00FF);
        RES_READY = 1'b0;
        send(16'h00FF, ok);
        wait_result(0, lat);
        checks++;
        if (!ok || lat != EXP_LAT || RES_DATA !== exp) begin
            errors++;
            $display("FAIL stall_result: got lat %0d data %h expected lat %0d data %h", lat, RES_DATA, EXP_LAT, exp);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            IN_DATA  = 16'($urandom);
            IN_VALID = (i % 2) == 1;
            step();
            if (RES_VALID !== 1'b1 || RES_DATA !== exp || IN_READY !== 1'b0) bad = 1'b1;
        end
        IN_VALID = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stall_stable: got unstable hold expected stable %h", exp);
        end
        RES_READY = 1'b1;
        step();
        checks++;
        if (RES_VALID !== 1'b0) begin
            errors++;
            $display("FAIL stall_accept: got %b expected 0", RES_VALID);
        end
        repeat (5) step();
        checks++;
        if (BUSY !== 1'b0 || runs < 0 || RES_DATA !== exp) begin
            errors++;
            $display("FAIL stall_no_queue: got busy %b data %h expected busy 0 data %h", BUSY, RES_DATA, exp);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lat;
        RES_READY = 1'b1;
        send(16'h1234, ok);
        repeat (7) step();
        #2;
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({IN_READY, RES_VALID, DATA_IN, READ_MODE, BUSY} !== 5'b0 || RES_DATA !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_outputs: got ctl %b data %h expected 00000 data 0000",
                     {IN_READY, RES_VALID, DATA_IN, READ_MODE, BUSY}, RES_DATA);
        end
        step();
        RESET_N = 1'b1;
        repeat (2) step();
        send(16'h0001, ok);
        wait_result(0, lat);
        checks++;
        if (!ok || lat != EXP_LAT || RES_DATA !== 16'h1021) begin
            errors++;
            $display("FAIL midreset_recover: got lat %0d data %h expected lat %0d data 1021", lat, RES_DATA, EXP_LAT);
        end
        step();
    endtask

    task automatic test_random();
        bit ok;
        int lat;
        logic [15:0] w;
        for (int n = 0; n < 200; n++) begin
            w = 16'($urandom);
            RES_READY = 1'b0;
            repeat ($urandom_range(0, 2)) step();
            send(w, ok);
            wait_result(0, lat);
            checks++;
            if (!ok || lat != EXP_LAT) begin
                errors++;
                $display("FAIL random_latency[%0d]: got %0d expected %0d", n, lat, EXP_LAT);
            end
            checks++;
            if (RES_DATA !== crc_ref(w)) begin
                errors++;
                $display("FAIL random_result[%0d]: word %h got %h expected %h", n, w, RES_DATA, crc_ref(w));
            end
            repeat ($urandom_range(0, 3)) step();
            RES_READY = 1'b1;
            step();
            RES_READY = 1'b0;
        end
    endtask

    task automatic test_engine_contract();
        checks++;
        if (rd_violations != 0) begin
            errors++;
            $display("FAIL data_in_during_read: got %0d cycles expected 0", rd_violations);
        end
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
`ifdef CRC_SEQ_AUTORUN_EN
        test_autorun();
`else
        test_single();
        test_back_to_back();
        test_hold_stall();
        test_reset_mid();
        test_random();
        test_engine_contract();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
